histo_frame_parser: RTL and testbench
=====================================

Name: histo_frame_parser

Overview:
- Receiving end of the photon-histogram pipe stream; recovers the bin counts the counter block packs into frames.
- Frame format: header 0xFEED, then NBINS data words with bytes swapped, then trailer 0x0FED.
- Reads words from a FIFO read port and validates framing. Good frames are summed into per-bin accumulators; bad frames are discarded.
- Accumulators are readable through a registered address/data port. Sits after a pipefifo in loopback/self-test and host-side emulation builds.

Parameters:
- NBINS, 26, data words per frame and number of accumulator bins.
- ACC_W, 32, accumulator width in bits, saturating.
- ADDR_W, 5, readout address width; must satisfy 2^ADDR_W >= NBINS.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  16  FIFO read data, valid the cycle after in_rd_en.
- in_empty  in  1  FIFO empty flag.
- in_rd_en  out  1  FIFO read strobe.
- clear  in  1  one-cycle pulse; zeroes accumulators and counters.
- rd_addr  in  ADDR_W  accumulator readout address.
- rd_data  out  ACC_W  accumulator value, 1-cycle latency.
- frame_done  out  1  one-cycle pulse when a frame has been committed.
- frame_err  out  1  one-cycle pulse on a bad trailer.
- frame_cnt  out  16  frames committed, saturating.
- err_cnt  out  16  bad trailers, saturating.
- disc_cnt  out  16  words discarded while hunting, saturating.

Behaviour:
Reset:
- All outputs 0, state HUNT, accumulators and staging registers 0, no read pending.

Read handshake:
- in_rd_en = ~in_empty & ~pending & (state != COMMIT) & ~clear & ~reset.
- pending is in_rd_en registered. It marks a word as valid the next cycle; that word is consumed in the state current on that cycle.
- At most one read is outstanding, so maximum throughput is one word per 2 clk.

States:
- HUNT: word == 0xFEED -> DATA, index = 0. Any other word is dropped and disc_cnt += 1.
- DATA: staging[index] = {w[7:0], w[15:8]}, index += 1. After word NBINS-1 -> TRAIL. 0xFEED and 0x0FED are ordinary data here; there is no escaping.
- TRAIL, word == 0x0FED: -> COMMIT, index = 0.
- TRAIL, any other word: frame_err pulse, err_cnt += 1, staging discarded. If that word == 0xFEED, it also counts as a new header (-> DATA, index = 0). Otherwise -> HUNT; this word does not increment disc_cnt.
- COMMIT: one bin per cycle, acc[index] = min(acc[index] + staging[index], 2^ACC_W - 1). The 16-bit addend is zero-extended. After bin NBINS-1: frame_done pulse, frame_cnt += 1, -> HUNT.
- COMMIT takes exactly NBINS cycles, and no reads are issued during it.
- A read issued in the TRAIL cycle is never in flight on COMMIT entry, because of the pending rule.

Counters:
- All three 16-bit counters saturate at 0xFFFF.

clear:
- Priority below reset, above everything else.
- Same cycle: accumulators, frame_cnt, err_cnt and disc_cnt go to 0, state -> HUNT, staging is invalidated.
- A word returning the cycle after clear is dropped without counting.
- An interrupted frame produces no frame_done and no frame_err.
- clear during COMMIT aborts the commit; partially updated bins are zeroed by the clear.

Readout:
- rd_data <= (rd_addr < NBINS) ? acc[rd_addr] : 0, registered.
- During COMMIT a bin updated on cycle t reads its new value from address t+1 onward.

Reset mid-operation:
- Identical to the power-up reset state. FIFO contents are not flushed, so the parser re-hunts for a header.

Test Plan:
- Good frame, FIFO preloaded FEED, bins i = 0x0100*(i+1) byte-swapped on the wire (so wire word i = 0x00nn with nn = i+1), then 0FED -> after NBINS commit cycles frame_done = 1 once; rd_data at addr 3 = 0x400; frame_cnt = 1; err_cnt = 0.
- Three garbage words 0x1234, 0x0FED, 0xAAAA, then a good frame -> disc_cnt = 3, frame_cnt = 1, bins correct.
- Bad trailers:
  - Frame with trailer 0x0BAD -> frame_err pulse, err_cnt = 1, accumulators unchanged.
  - Frame with trailer 0xFEED followed by NBINS words and 0FED -> err_cnt = 1, frame_cnt = 1, second frame's data accumulated.
- Saturation: ACC_W = 17, two frames of all-0xFFFF bins -> each bin = 0x1FFFE; third frame -> 0x1FFFF; frame_cnt = 3.
- FIFO control and readout:
  - FIFO empty mid-frame for 10 cycles, then resumed -> in_rd_en low while empty, frame still commits correctly.
  - in_rd_en never asserted on consecutive cycles or during COMMIT.
  - rd_addr = 31 -> rd_data = 0.
- clear pulse on commit cycle 5 -> all bins 0, frame_done never pulses, state HUNT. Reset asserted during DATA, then a fresh frame -> only the fresh frame accumulated, frame_cnt = 1.

Source files
------------

// File: rtl/histo_frame_parser_if.sv
// FIFO read-port bundle between a pipefifo and the frame parser.
// master = consumer issuing the read strobe; slave = FIFO returning data one cycle later.
interface histo_frame_parser_if;
   logic [15:0] in_data;
   logic        in_empty;
   logic        in_rd_en;

   modport master (input in_data, input in_empty, output in_rd_en);
   modport slave  (output in_data, output in_empty, input in_rd_en);
endinterface

// File: rtl/histo_frame_parser.sv
// Recovers histogram frames (FEED, NBINS byte-swapped bins, 0FED) from a FIFO and sums good ones into
// saturating bins; one read outstanding (1 word / 2 clk), NBINS-cycle commit with reads stalled, 1-cycle readout.
module histo_frame_parser #(
   parameter int NBINS  = 26,
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   histo_frame_parser_if.master  fifo,
   input  logic                  clear,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [ACC_W-1:0]      rd_data,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [15:0]           frame_cnt,
   output logic [15:0]           err_cnt,
   output logic [15:0]           disc_cnt
);
   localparam int IDX_W = (NBINS > 1) ? $clog2(NBINS) : 1;
   localparam logic [15:0] HDR = 16'hFEED;
   localparam logic [15:0] TRL = 16'h0FED;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NBINS - 1);

   typedef enum logic [1:0] {HUNT, DATA, TRAIL, COMMIT} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               pending_q;
   logic [15:0]        staging_q [NBINS];
   logic [ACC_W-1:0]   acc_q [NBINS];
   logic [15:0]        frame_cnt_q, err_cnt_q, disc_cnt_q;
   logic               frame_done_q, frame_err_q;
   logic [ACC_W-1:0]   rd_data_q, rd_mux;
   logic [15:0]        word;
   logic [ACC_W:0]     sum;
   logic               word_vld, is_last, stage_we, commit_en, done_d, err_d, disc_inc;

   assign word = fifo.in_data;
   assign sum  = {1'b0, acc_q[idx_q]} + {{(ACC_W-15){1'b0}}, staging_q[idx_q]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= HUNT;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (clear) begin
         state_d = HUNT;
         idx_d   = '0;
      end else begin
         case (state_q)
            HUNT: if (word_vld && word == HDR) begin
               state_d = DATA;
               idx_d   = '0;
            end
            DATA: if (word_vld) begin
               idx_d = is_last ? '0 : idx_q + 1'b1;
               if (is_last) state_d = TRAIL;
            end
            // A bad trailer that happens to be FEED doubles as the next header.
            TRAIL: if (word_vld) begin
               idx_d = '0;
               if (word == TRL)      state_d = COMMIT;
               else if (word == HDR) state_d = DATA;
               else                  state_d = HUNT;
            end
            COMMIT: begin
               idx_d = is_last ? '0 : idx_q + 1'b1;
               if (is_last) state_d = HUNT;
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      fifo.in_rd_en = ~fifo.in_empty && ~pending_q && (state_q != COMMIT) && ~clear && ~reset;
      word_vld      = pending_q && ~clear;
      is_last       = (idx_q == LAST);
      stage_we      = word_vld && (state_q == DATA);
      commit_en     = ~clear && (state_q == COMMIT);
      done_d        = commit_en && is_last;
      err_d         = word_vld && (state_q == TRAIL) && (word != TRL);
      disc_inc      = word_vld && (state_q == HUNT) && (word != HDR);
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NBINS; i++) begin
         if (rd_addr == ADDR_W'(i)) rd_mux = acc_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         rd_data_q    <= '0;
         frame_cnt_q  <= '0;
         err_cnt_q    <= '0;
         disc_cnt_q   <= '0;
         for (int i = 0; i < NBINS; i++) begin
            staging_q[i] <= '0;
            acc_q[i]     <= '0;
         end
      end else begin
         pending_q    <= fifo.in_rd_en;
         frame_done_q <= done_d;
         frame_err_q  <= err_d;
         rd_data_q    <= rd_mux;
         if (stage_we) staging_q[idx_q] <= {word[7:0], word[15:8]};
         if (clear) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            disc_cnt_q  <= '0;
            for (int i = 0; i < NBINS; i++) acc_q[i] <= '0;
         end else begin
            if (commit_en) acc_q[idx_q] <= sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            if (done_d   && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (err_d    && err_cnt_q   != 16'hFFFF) err_cnt_q   <= err_cnt_q + 1'b1;
            if (disc_inc && disc_cnt_q  != 16'hFFFF) disc_cnt_q  <= disc_cnt_q + 1'b1;
         end
      end
   end

   assign rd_data    = rd_data_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign frame_cnt  = frame_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign disc_cnt   = disc_cnt_q;
endmodule

// File: tb/tb_histo_frame_parser.sv
// Directed bench for histo_frame_parser with a queue-backed FIFO model and a bin scoreboard.
module tb_histo_frame_parser;
   localparam int NBINS  = 26;
   localparam int ACC_W  = 17;
   localparam int ADDR_W = 5;
   localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

   logic              clk = 1'b0;
   logic              reset, clear;
   logic [ADDR_W-1:0] rd_addr;
   logic [ACC_W-1:0]  rd_data;
   logic              frame_done, frame_err;
   logic [15:0]       frame_cnt, err_cnt, disc_cnt;

   histo_frame_parser_if bus();

   histo_frame_parser #(.NBINS(NBINS), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_dut (
      .clk(clk), .reset(reset), .fifo(bus.master), .clear(clear),
      .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done), .frame_err(frame_err),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt), .disc_cnt(disc_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // FIFO model: data appears the cycle after the read strobe.
   logic [15:0] fifo_q [$];
   int          pop_cyc [$];
   int          cyc = 0, pop_n = 0, empty_viol = 0, b2b_viol = 0;
   logic        prev_rd = 1'b0;
   int          done_n = 0, err_n = 0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      prev_rd <= bus.in_rd_en;
      if (bus.in_rd_en) begin
         if (prev_rd) b2b_viol <= b2b_viol + 1;
         if (fifo_q.size() == 0) empty_viol <= empty_viol + 1;
         else begin
            bus.in_data <= fifo_q.pop_front();
            pop_cyc.push_back(cyc);
            pop_n <= pop_n + 1;
         end
      end
   end

   always @(negedge clk) begin
      bus.in_empty = (fifo_q.size() == 0);
      if (frame_done) done_n <= done_n + 1;
      if (frame_err)  err_n  <= err_n + 1;
   end

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [ACC_W-1:0]  exp;
   } rd_vec_t;
   rd_vec_t rd_tbl [6];

   logic [15:0]      frame_b [NBINS];
   logic [ACC_W-1:0] exp_acc [NBINS];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_body(input logic [15:0] trailer);
      for (int i = 0; i < NBINS; i++) fifo_q.push_back({frame_b[i][7:0], frame_b[i][15:8]});
      fifo_q.push_back(trailer);
   endtask

   task automatic push_frame(input logic [15:0] trailer);
      fifo_q.push_back(16'hFEED);
      push_body(trailer);
   endtask

   task automatic model_add();
      logic [ACC_W:0] s;
      for (int i = 0; i < NBINS; i++) begin
         s = {1'b0, exp_acc[i]} + {{(ACC_W-15){1'b0}}, frame_b[i]};
         exp_acc[i] = s[ACC_W] ? ACC_MAX : s[ACC_W-1:0];
      end
   endtask

   task automatic model_zero();
      for (int i = 0; i < NBINS; i++) exp_acc[i] = '0;
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_n < n && t < 600) begin @(negedge clk); t++; end
      @(negedge clk);
      chk("frame_done pulses", done_n, n);
   endtask

   task automatic wait_err(input int n);
      int t = 0;
      while (err_n < n && t < 600) begin @(negedge clk); t++; end
      @(negedge clk);
      chk("frame_err pulses", err_n, n);
   endtask

   task automatic wait_pops(input int n);
      int t = 0;
      while (pop_n < n && t < 600) begin @(negedge clk); t++; end
      chk("fifo pops reached", pop_n, n);
   endtask

   task automatic read_bin(input logic [ADDR_W-1:0] a, output logic [ACC_W-1:0] v);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      v = rd_data;
   endtask

   task automatic check_bins(input string name);
      logic [ACC_W-1:0] v;
      for (int i = 0; i < NBINS; i++) begin
         read_bin(ADDR_W'(i), v);
         chk($sformatf("%s bin%0d", name, i), v, exp_acc[i]);
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_zero();
   endtask

   initial begin
      logic [ACC_W-1:0] v;
      int base, done_base;

      rd_tbl[0] = '{5'd0,  17'h00100};
      rd_tbl[1] = '{5'd3,  17'h00400};
      rd_tbl[2] = '{5'd12, 17'h00D00};
      rd_tbl[3] = '{5'd25, 17'h01A00};
      rd_tbl[4] = '{5'd26, 17'h00000};
      rd_tbl[5] = '{5'd31, 17'h00000};

      reset = 1'b1; clear = 1'b0; rd_addr = '0;
      model_zero();
      repeat (3) @(negedge clk);
      chk("rst frame_done", frame_done, 0);
      chk("rst frame_err", frame_err, 0);
      chk("rst frame_cnt", frame_cnt, 0);
      chk("rst err_cnt", err_cnt, 0);
      chk("rst disc_cnt", disc_cnt, 0);
      chk("rst rd_data", rd_data, 0);
      chk("rst in_rd_en", bus.in_rd_en, 0);
      reset = 1'b0;

      // Good frame followed by one garbage word.
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h0100 * 16'(i + 1);
      push_frame(16'h0FED);
      fifo_q.push_back(16'h1234);
      wait_done(1);
      model_add();
      repeat (6) @(negedge clk);
      chk("f1 frame_cnt", frame_cnt, 1);
      chk("f1 err_cnt", err_cnt, 0);
      chk("f1 disc_cnt", disc_cnt, 1);
      chk("f1 err pulses", err_n, 0);
      chk("commit read gap", pop_cyc[28] - pop_cyc[27], NBINS + 2);
      for (int k = 0; k < 6; k++) begin
         read_bin(rd_tbl[k].addr, v);
         chk($sformatf("tbl addr%0d", rd_tbl[k].addr), v, rd_tbl[k].exp);
      end

      // More garbage including a stray trailer, then a second good frame.
      fifo_q.push_back(16'h0FED);
      fifo_q.push_back(16'hAAAA);
      push_frame(16'h0FED);
      wait_done(2);
      model_add();
      chk("f2 disc_cnt", disc_cnt, 3);
      chk("f2 frame_cnt", frame_cnt, 2);
      check_bins("f2");

      do_clear();
      chk("clr frame_cnt", frame_cnt, 0);
      chk("clr disc_cnt", disc_cnt, 0);
      read_bin(5'd3, v);
      chk("clr bin3", v, 0);

      // Bad trailer 0x0BAD: discarded.
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h0011 * 16'(i);
      push_frame(16'h0BAD);
      wait_err(1);
      repeat (4) @(negedge clk);
      chk("bad err_cnt", err_cnt, 1);
      chk("bad frame_cnt", frame_cnt, 0);
      chk("bad done pulses", done_n, 2);
      check_bins("bad");

      // Trailer FEED restarts as header for the following frame.
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h2222;
      push_frame(16'hFEED);
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h1000 + 16'(i);
      push_body(16'h0FED);
      wait_done(3);
      model_add();
      chk("feed err pulses", err_n, 2);
      chk("feed err_cnt", err_cnt, 2);
      chk("feed frame_cnt", frame_cnt, 1);
      chk("feed disc_cnt", disc_cnt, 0);
      check_bins("feed");

      // Saturation with ACC_W = 17.
      do_clear();
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'hFFFF;
      push_frame(16'h0FED);
      push_frame(16'h0FED);
      wait_done(5);
      read_bin(5'd0, v);
      chk("sat2 bin0", v, 17'h1FFFE);
      read_bin(5'd25, v);
      chk("sat2 bin25", v, 17'h1FFFE);
      push_frame(16'h0FED);
      wait_done(6);
      read_bin(5'd0, v);
      chk("sat3 bin0", v, 17'h1FFFF);
      read_bin(5'd17, v);
      chk("sat3 bin17", v, 17'h1FFFF);
      chk("sat frame_cnt", frame_cnt, 3);

      // FIFO runs dry mid-frame.
      do_clear();
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h0A00 + 16'(i);
      base = pop_n;
      fifo_q.push_back(16'hFEED);
      for (int i = 0; i < 10; i++) fifo_q.push_back({frame_b[i][7:0], frame_b[i][15:8]});
      wait_pops(base + 11);
      base = pop_n;
      repeat (10) @(negedge clk);
      chk("dry no reads", pop_n, base);
      chk("dry no empty reads", empty_viol, 0);
      for (int i = 10; i < NBINS; i++) fifo_q.push_back({frame_b[i][7:0], frame_b[i][15:8]});
      fifo_q.push_back(16'h0FED);
      wait_done(7);
      model_add();
      chk("dry frame_cnt", frame_cnt, 1);
      check_bins("dry");

      // clear on commit cycle 5 aborts the commit.
      do_clear();
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h0300 + 16'(i);
      base = pop_n;
      done_base = done_n;
      push_frame(16'h0FED);
      wait_pops(base + NBINS + 2);
      repeat (6) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (30) @(negedge clk);
      chk("abort done pulses", done_n, done_base);
      chk("abort frame_cnt", frame_cnt, 0);
      check_bins("abort");
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h0040 + 16'(i);
      push_frame(16'h0FED);
      wait_done(done_base + 1);
      model_add();
      chk("post-abort frame_cnt", frame_cnt, 1);
      check_bins("post-abort");

      // Reset during DATA; the parser must re-hunt.
      do_clear();
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h0500 + 16'(i);
      base = pop_n;
      fifo_q.push_back(16'hFEED);
      for (int i = 0; i < 10; i++) fifo_q.push_back({frame_b[i][7:0], frame_b[i][15:8]});
      wait_pops(base + 11);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("midrst in_rd_en", bus.in_rd_en, 0);
      chk("midrst rd_data", rd_data, 0);
      reset = 1'b0;
      done_base = done_n;
      for (int i = 0; i < NBINS; i++) frame_b[i] = 16'h0600 + 16'(i);
      push_frame(16'h0FED);
      wait_done(done_base + 1);
      model_add();
      chk("midrst frame_cnt", frame_cnt, 1);
      chk("midrst err_cnt", err_cnt, 0);
      check_bins("midrst");

      chk("back-to-back reads", b2b_viol, 0);
      chk("reads while empty", empty_viol, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
